stream_packer: RTL and testbench

//  Parametrised successor to the fixed 16b->128b packer used on the softmax datapath.

---
 rtl/softmax_pkg.sv | 10 +
 rtl/pkt_out_reg.sv | 46 ++++
 rtl/stream_packer.sv | 119 +++++++++++
 tb/tb_stream_packer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared widths and types for the softmax datapath.
package softmax_pkg;

   localparam int SM_DATA_W   = 16;
   localparam int SM_PACK_NUM = 8;

   typedef logic [SM_DATA_W-1:0]             sm_word_t;
   typedef logic [SM_DATA_W*SM_PACK_NUM-1:0] sm_pkt_t;

endpackage

// File: rtl/pkt_out_reg.sv
// Output holding register for stream_packer: one packet plus word count,
// presented on valid/ready and held stable until accepted.
module pkt_out_reg
   import softmax_pkg::*;
#(
   parameter int OUT_W = SM_DATA_W * SM_PACK_NUM,
   parameter int CNT_W = $clog2(SM_PACK_NUM + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [OUT_W-1:0] load_data,
   input  logic [CNT_W-1:0] load_cnt,
   output logic             can_load,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_cnt
);

   logic             valid_reg;
   logic [OUT_W-1:0] data_reg;
   logic [CNT_W-1:0] cnt_reg;

   // A new packet may enter when the register is empty or is being drained now.
   assign can_load = !valid_reg || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         cnt_reg   <= '0;
      end else if (load) begin
         valid_reg <= 1'b1;
         data_reg  <= load_data;
         cnt_reg   <= load_cnt;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign out_valid = valid_reg;
   assign out_data  = data_reg;
   assign out_cnt   = cnt_reg;

endmodule

// File: rtl/stream_packer.sv
// Packs PACK_NUM words from a 1-cycle-latency FIFO into one packet, double-buffered.
// Optional partial-packet flush port enabled by STREAM_PACKER_FLUSH_EN.
module stream_packer
   import softmax_pkg::*;
#(
   parameter  int DATA_W   = SM_DATA_W,
   parameter  int PACK_NUM = SM_PACK_NUM,
   localparam int OUT_W    = DATA_W * PACK_NUM,
   localparam int CNT_W    = $clog2(PACK_NUM + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              fifo_empty,
   output logic              rd_en,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef STREAM_PACKER_FLUSH_EN
   input  logic              flush,
`endif
   output logic [CNT_W-1:0]  out_cnt,
   output logic              busy
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_NUM);

   logic              run_reg;
   logic              pend_reg;
   logic [CNT_W-1:0]  asm_cnt_reg;
   logic [CNT_W-1:0]  asm_cnt_next;
   logic [CNT_W-1:0]  fill;
   logic [CNT_W-1:0]  pkt_cnt;
   logic [DATA_W-1:0] asm_word_reg [PACK_NUM];
   logic [OUT_W-1:0]  pkt_data;
   logic              can_load;
   logic              move;

   // fill counts the word landing this cycle, so the last word of a packet
   // moves straight to the output register without an extra cycle.
   assign fill = asm_cnt_reg + CNT_W'(pend_reg);

`ifdef STREAM_PACKER_FLUSH_EN
   logic flush_pend_reg;
   logic flush_req;

   assign flush_req = flush || flush_pend_reg;
   assign move      = can_load && ((fill == FULL_CNT) || (flush_req && (fill != '0)));
   assign rd_en     = run_reg && !fifo_empty && !flush_req && ((fill < FULL_CNT) || move);
   assign pkt_cnt   = fill;

   // Remembers a flush until the output register has room for the partial packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_pend_reg <= 1'b0;
      end else if (move) begin
         flush_pend_reg <= 1'b0;
      end else if (flush && (fill != '0)) begin
         flush_pend_reg <= 1'b1;
      end
   end
`else
   assign move    = can_load && (fill == FULL_CNT);
   assign rd_en   = run_reg && !fifo_empty && ((fill < FULL_CNT) || move);
   assign pkt_cnt = FULL_CNT;
`endif

   assign asm_cnt_next = move ? '0 : fill;

   // run_reg keeps rd_en low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_reg     <= 1'b0;
         pend_reg    <= 1'b0;
         asm_cnt_reg <= '0;
      end else begin
         run_reg     <= 1'b1;
         pend_reg    <= rd_en;
         asm_cnt_reg <= asm_cnt_next;
      end
   end

   // Slots are cleared on every move so a flushed packet is zero padded.
   for (genvar gi = 0; gi < PACK_NUM; gi++) begin : g_slot
      logic hit;
      assign hit = pend_reg && (asm_cnt_reg == CNT_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            asm_word_reg[gi] <= '0;
         end else if (move) begin
            asm_word_reg[gi] <= '0;
         end else if (hit) begin
            asm_word_reg[gi] <= fifo_data;
         end
      end

      assign pkt_data[gi*DATA_W +: DATA_W] = hit ? fifo_data : asm_word_reg[gi];
   end

   pkt_out_reg #(
      .OUT_W (OUT_W),
      .CNT_W (CNT_W)
   ) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (move),
      .load_data (pkt_data),
      .load_cnt  (pkt_cnt),
      .can_load  (can_load),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cnt   (out_cnt)
   );

   assign busy = (asm_cnt_reg != '0) || pend_reg || out_valid;

endmodule

// File: tb/tb_stream_packer.sv
// Randomised bench for stream_packer: FIFO model, packet scoreboard, timing checks.
module tb_stream_packer;
   import softmax_pkg::*;

   localparam int DATA_W   = SM_DATA_W;
   localparam int PACK_NUM = SM_PACK_NUM;
   localparam int OUT_W    = DATA_W * PACK_NUM;
   localparam int CNT_W    = $clog2(PACK_NUM + 1);

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_empty;
   logic              rd_en;
   logic [OUT_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  out_cnt;
   logic              busy;
`ifdef STREAM_PACKER_FLUSH_EN
   logic              flush;
`endif

   stream_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .rd_en      (rd_en),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef STREAM_PACKER_FLUSH_EN
      .flush      (flush),
`endif
      .out_cnt    (out_cnt),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DATA_W-1:0] fifo_q[$];
   logic [DATA_W-1:0] cur_words[$];
   logic [OUT_W-1:0]  exp_data_q[$];
   int                exp_cnt_q[$];
   int                acc_cyc[$];

   int               n_vec = 0;
   int               n_err = 0;
   int               cycle = 0;
   int               pops  = 0;
   int               pkts  = 0;
   int               first_rd_cyc    = -1;
   int               first_valid_cyc = -1;
   bit               rand_empty = 0;
   bit               rand_ready = 0;
   logic [OUT_W-1:0] last_pkt;
   int               last_cnt;
   logic [OUT_W-1:0] exp_pkt;

   task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: every word read, in order, grouped PACK_NUM at a time, word 0 lowest.
   function automatic void model_emit();
      logic [OUT_W-1:0] pkt;
      pkt = '0;
      for (int i = 0; i < cur_words.size(); i++)
         pkt = pkt | (OUT_W'(cur_words[i]) << (i * DATA_W));
      exp_data_q.push_back(pkt);
      exp_cnt_q.push_back(cur_words.size());
      cur_words.delete();
   endfunction

   function automatic void model_push(input logic [DATA_W-1:0] w);
      cur_words.push_back(w);
      if (cur_words.size() == PACK_NUM) model_emit();
   endfunction

   task automatic set_inputs();
      fifo_empty = (fifo_q.size() == 0) || (rand_empty && ($urandom_range(1, 0) == 0));
      if (rand_ready) out_ready = ($urandom_range(3, 0) != 0);
   endtask

   task automatic push_word(input logic [DATA_W-1:0] w);
      fifo_q.push_back(w);
      set_inputs();
   endtask

   // One clock: sample at the falling edge, update FIFO model after the rising edge.
   task automatic tick();
      logic rd_s;
      @(negedge clk);
      rd_s = rd_en;
      chk("rd_while_empty", OUT_W'(rd_en && fifo_empty), OUT_W'(0));
      if (rd_s && first_rd_cyc < 0) first_rd_cyc = cycle;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cycle;
      if (out_valid && out_ready) begin
         pkts++;
         acc_cyc.push_back(cycle);
         last_pkt = out_data;
         last_cnt = int'(out_cnt);
         chk("pkt_expected", OUT_W'(exp_data_q.size() != 0), OUT_W'(1));
         if (exp_data_q.size() != 0) begin
            chk("pkt_data", out_data, exp_data_q.pop_front());
            chk("pkt_cnt", OUT_W'(out_cnt), OUT_W'(exp_cnt_q.pop_front()));
         end
      end
      @(posedge clk);
      #1;
      if (rd_s && fifo_q.size() != 0) begin
         fifo_data = fifo_q.pop_front();
         pops++;
         model_push(fifo_data);
      end else begin
         fifo_data = DATA_W'($urandom);
      end
      cycle++;
      set_inputs();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_data_q.size() != 0 || fifo_q.size() != 0 || busy) && n < 3000) begin
         tick();
         n++;
      end
      chk(tag, OUT_W'(exp_data_q.size() != 0 || fifo_q.size() != 0 || busy), OUT_W'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fifo_q.delete();
      cur_words.delete();
      exp_data_q.delete();
      exp_cnt_q.delete();
      set_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      pops = 0;
      pkts = 0;
      acc_cyc.delete();
      first_rd_cyc = -1;
      first_valid_cyc = -1;
   endtask

   initial begin
      rst_n      = 1'b0;
      out_ready  = 1'b1;
      fifo_data  = '0;
      fifo_empty = 1'b1;
`ifdef STREAM_PACKER_FLUSH_EN
      flush      = 1'b0;
`endif
      // Reset state, with a non-empty FIFO so rd_en is really tested.
      for (int i = 1; i <= 8; i++) push_word(DATA_W'(i));
      repeat (2) @(negedge clk);
      chk("rst_rd_en", OUT_W'(rd_en), OUT_W'(0));
      chk("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
      chk("rst_out_data", out_data, OUT_W'(0));
      chk("rst_out_cnt", OUT_W'(out_cnt), OUT_W'(0));
      chk("rst_busy", OUT_W'(busy), OUT_W'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1: eight words, latency and packet layout.
      for (int n = 0; n < 50 && first_valid_cyc < 0; n++) tick();
      chk("latency", OUT_W'(first_valid_cyc - first_rd_cyc), OUT_W'(PACK_NUM + 1));
      drain("t1_drain");
      exp_pkt = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
      chk("t1_data", last_pkt, exp_pkt);
      chk("t1_cnt", OUT_W'(last_cnt), OUT_W'(PACK_NUM));

      // 2: continuous stream, back-to-back reads and packet spacing.
      do_reset();
      for (int i = 0; i < 32; i++) push_word(DATA_W'(i));
      for (int n = 0; n < 200 && pops < 32; n++) tick();
      chk("t2_rd_continuous", OUT_W'(cycle - first_rd_cyc), OUT_W'(32));
      drain("t2_drain");
      chk("t2_pkts", OUT_W'(pkts), OUT_W'(4));
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("t2_spacing", OUT_W'(acc_cyc[i] - acc_cyc[i-1]), OUT_W'(PACK_NUM));

      // 3: consumer stall, two packets buffered then reads stop.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 48; i++) push_word(DATA_W'(16'h0300 + i));
      repeat (30) tick();
      chk("t3_buffered_words", OUT_W'(pops), OUT_W'(2 * PACK_NUM));
      chk("t3_rd_stalled", OUT_W'(rd_en), OUT_W'(0));
      chk("t3_out_valid", OUT_W'(out_valid), OUT_W'(1));
      out_ready = 1'b1;
      drain("t3_drain");
      chk("t3_pkts", OUT_W'(pkts), OUT_W'(6));

      // 4: random FIFO gaps and random back-pressure.
      do_reset();
      rand_empty = 1;
      rand_ready = 1;
      for (int i = 0; i < 64; i++) push_word(DATA_W'($urandom));
      drain("t4_drain");
      chk("t4_pkts", OUT_W'(pkts), OUT_W'(8));
      rand_empty = 0;
      rand_ready = 0;
      out_ready  = 1'b1;

      // 5: reset mid-packet discards the partial packet.
      do_reset();
      for (int i = 0; i < 16; i++) push_word(DATA_W'(16'h0500 + i));
      for (int n = 0; n < 50 && pops < 3; n++) tick();
      do_reset();
      for (int i = 0; i < 8; i++) push_word(DATA_W'(16'h00A0 + i));
      drain("t5_drain");
      chk("t5_pkts", OUT_W'(pkts), OUT_W'(1));
      exp_pkt = 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0;
      chk("t5_data", last_pkt, exp_pkt);

`ifdef STREAM_PACKER_FLUSH_EN
      // 6: flush of a three-word partial packet, then a normal packet.
      do_reset();
      push_word(DATA_W'(16'h0011));
      push_word(DATA_W'(16'h0022));
      push_word(DATA_W'(16'h0033));
      for (int n = 0; n < 50 && pops < 3; n++) tick();
      if (cur_words.size() != 0) model_emit();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drain("t6_flush_drain");
      exp_pkt = 128'h0033_0022_0011;
      chk("t6_flush_data", last_pkt, exp_pkt);
      chk("t6_flush_cnt", OUT_W'(last_cnt), OUT_W'(3));
      for (int i = 0; i < 8; i++) push_word(DATA_W'(16'h0600 + i));
      drain("t6_full_drain");
      chk("t6_pkts", OUT_W'(pkts), OUT_W'(2));
      chk("t6_full_cnt", OUT_W'(last_cnt), OUT_W'(PACK_NUM));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
